// File: rtl/sar_redundant_ctrl_pkg.sv
// Shared types and default step-weight tables for the redundant-weight SAR controller.
// Used by sar_redundant_ctrl and sar_step_table.
package sar_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      CONV   = 2'd2,
      DONE   = 2'd3
   } sar_state_t;

   // Index 0 is the smallest weight; the sum is 4095 so every 12-bit code is reachable.
   localparam int DEF_STEPS_12B_14S [14] = '{1, 2, 3, 4, 8, 14, 26, 45, 80, 144, 253, 456, 1011, 2048};

   // Binary weights on the top NBITS steps, extra steps padded with weight 1 below them.
   function automatic int default_step(input int nbits, input int nsteps, input int idx);
      int lsb_steps;
      lsb_steps = nsteps - nbits;
      if ((nbits == 12) && (nsteps == 14)) begin
         return DEF_STEPS_12B_14S[idx];
      end
      if (idx >= lsb_steps) begin
         return 1 << (idx - lsb_steps);
      end
      return 1;
   endfunction

endpackage

// File: rtl/sar_redundant_ctrl_step_table.sv
// Step-weight table for the SAR controller, read by the step pointer.
// Writable at runtime only when SAR_STEP_PROG_EN is defined; otherwise a constant ROM of defaults.
module sar_step_table
   import sar_pkg::*;
#(
   parameter int NBITS  = 12,
   parameter int NSTEPS = 14,
   parameter int PTR_W  = 4
) (
   input  logic             clkin,
   input  logic             rst,
   input  logic             wr_en,
   input  logic             wr_allow,
   input  logic [PTR_W-1:0] wr_addr,
   input  logic [NBITS-1:0] wr_data,
   input  logic [PTR_W-1:0] rd_addr,
   output logic [NBITS-1:0] rd_data
);

   logic [NBITS-1:0] steps [NSTEPS];

`ifdef SAR_STEP_PROG_EN
   // Writes are only honoured while no conversion is using the table.
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NSTEPS; i++) begin
            steps[i] <= NBITS'(default_step(NBITS, NSTEPS, i));
         end
      end else if (wr_en && wr_allow && (int'(wr_addr) < NSTEPS)) begin
         steps[wr_addr] <= wr_data;
      end
   end
`else
   for (genvar i = 0; i < NSTEPS; i++) begin : g_rom
      assign steps[i] = NBITS'(default_step(NBITS, NSTEPS, i));
   end

   logic unused_tbl;
   assign unused_tbl = ^{clkin, rst, wr_en, wr_allow, wr_addr, wr_data};
`endif

   assign rd_data = steps[rd_addr];

endmodule

// File: rtl/sar_redundant_ctrl.sv
// SAR ADC controller with redundant step weights: samples on st_conv high, converts on its fall.
// Optional runtime step-table programming is enabled by defining SAR_STEP_PROG_EN.
module sar_redundant_ctrl
   import sar_pkg::*;
#(
   parameter int NBITS  = 12,
   parameter int NSTEPS = 14,
   parameter int PTR_W  = 4
) (
   input  logic             clkin,
   input  logic             rst,
   input  logic             st_conv,
   input  logic             comp_in,
   output logic             clkout,
   output logic             sample,
   output logic [NBITS-1:0] dac_value,
   output logic [NBITS-1:0] result,
   output logic             result_valid,
   output logic             busy,
   input  logic             tbl_we,
   input  logic [PTR_W-1:0] tbl_addr,
   input  logic [NBITS-1:0] tbl_wdata
);

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NSTEPS - 1);
   localparam logic [NBITS:0]   CODE_MAX = {1'b0, {NBITS{1'b1}}};

   if (NSTEPS < NBITS) begin : g_bad_nsteps
      $error("sar_redundant_ctrl: NSTEPS must be >= NBITS");
   end
   if ((1 << PTR_W) < NSTEPS) begin : g_bad_ptr_w
      $error("sar_redundant_ctrl: PTR_W too narrow for NSTEPS");
   end

   sar_state_t state;
   sar_state_t state_next;

   logic             st_q;
   logic             rise;
   logic             fall;
   logic [PTR_W-1:0] ptr;
   logic [NBITS:0]   acc;
   logic [NBITS-1:0] step_val;
   logic [NBITS+1:0] acc_sum;
   logic [NBITS:0]   acc_next;
   logic [NBITS:0]   final_acc;
   logic [NBITS-1:0] result_d;
   logic             last_step;
   logic             tbl_wr_allow;

   assign rise      = st_conv & ~st_q;
   assign fall      = ~st_conv & st_q;
   assign last_step = (ptr == '0);

   assign tbl_wr_allow = (state == IDLE) || (state == DONE);

   sar_step_table #(
      .NBITS (NBITS),
      .NSTEPS(NSTEPS),
      .PTR_W (PTR_W)
   ) u_step_table (
      .clkin   (clkin),
      .rst     (rst),
      .wr_en   (tbl_we),
      .wr_allow(tbl_wr_allow),
      .wr_addr (tbl_addr),
      .wr_data (tbl_wdata),
      .rd_addr (ptr),
      .rd_data (step_val)
   );

   // The accumulator is one bit wider than the code so a redundant table can overshoot;
   // the sum saturates there, and DAC code and result saturate to the code range.
   always_comb begin
      acc_sum   = {1'b0, acc} + {2'b00, step_val};
      acc_next  = acc_sum[NBITS+1] ? {(NBITS + 1){1'b1}} : acc_sum[NBITS:0];
      dac_value = (acc_next > CODE_MAX) ? CODE_MAX[NBITS-1:0] : acc_next[NBITS-1:0];
      final_acc = comp_in ? acc_next : acc;
      result_d  = (final_acc > CODE_MAX) ? CODE_MAX[NBITS-1:0] : final_acc[NBITS-1:0];
   end

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A rise of st_conv always restarts sampling, even in the middle of a conversion.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (rise) state_next = SAMPLE;
         end
         SAMPLE: begin
            if (fall) state_next = CONV;
         end
         CONV: begin
            if (rise) begin
               state_next = SAMPLE;
            end else if (last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = rise ? SAMPLE : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      sample       = 1'b0;
      busy         = 1'b0;
      result_valid = 1'b0;
      clkout       = 1'b0;
      unique case (state)
         SAMPLE: begin
            sample = 1'b1;
            busy   = 1'b1;
         end
         CONV: begin
            busy   = 1'b1;
            clkout = ~clkin;
         end
         DONE: begin
            result_valid = 1'b1;
         end
         default: ;
      endcase
   end

   // Outside an active comparison, ptr/acc idle at the first trial so dac_value shows the top step.
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         st_q   <= 1'b0;
         ptr    <= LAST_PTR;
         acc    <= '0;
         result <= '0;
      end else begin
         st_q <= st_conv;
         if ((state == CONV) && !rise && !last_step) begin
            if (comp_in) acc <= acc_next;
            ptr <= ptr - 1'b1;
         end else begin
            if ((state == CONV) && !rise) result <= result_d;
            ptr <= LAST_PTR;
            acc <= '0;
         end
      end
   end

endmodule
